// File: rtl/tpm_ram_arbiter.sv
// Request/grant scheduler sharing the TPM command/response RAM between the byte-wide
// data-provider port and the 32-bit Wishbone port: IDLE -> ACCESS -> RESP, one access per 3 cycles.
module tpm_ram_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int MAX_CONSEC = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  exec_i,
  input  logic                  dp_req_i,
  input  logic                  dp_we_i,
  input  logic [ADDR_WIDTH-1:0] dp_addr_i,
  input  logic [7:0]            dp_wdata_i,
  output logic [7:0]            dp_rdata_o,
  output logic                  dp_ack_o,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-3:0] wb_adr_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic [ADDR_WIDTH-3:0] ram_a_o,
  output logic [31:0]           ram_wd_o,
  output logic [3:0]            ram_wen_o,
  input  logic [31:0]           ram_rd_i,
  output logic                  owner_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_we;
  logic [1:0]            r_lane;
  logic [7:0]            r_dp_rdata;
  logic [31:0]           r_wb_dat;

  logic                  w_wb_req;
  logic                  w_dp_req;
  logic                  w_both;
  logic                  w_starved;
  logic                  w_win_wb;
  logic [ADDR_WIDTH-3:0] w_a;
  logic [31:0]           w_wd;
  logic [3:0]            w_wen;
  logic [7:0]            w_lane_byte;

  // Winner selection and the RAM command the winner would issue.
  always_comb begin
    w_wb_req  = wb_cyc_i & wb_stb_i;
    w_dp_req  = dp_req_i;
    w_both    = w_wb_req & w_dp_req;
    w_starved = (r_cnt == 4'(MAX_CONSEC));
    w_win_wb  = 1'b0;
    w_a       = '0;
    w_wd      = 32'h0000_0000;
    w_wen     = 4'b0000;
    if (w_both) begin
      w_win_wb = exec_i ^ w_starved;
    end else begin
      w_win_wb = w_wb_req;
    end
    if (w_win_wb) begin
      w_a   = wb_adr_i;
      w_wd  = wb_dat_i;
      w_wen = wb_we_i ? wb_sel_i : 4'b0000;
    end else begin
      w_a   = dp_addr_i[ADDR_WIDTH-1:2];
      w_wd  = {4{dp_wdata_i}};
      w_wen = dp_we_i ? (4'b0001 << dp_addr_i[1:0]) : 4'b0000;
    end
  end

  // Byte lane of the RAM read word for the DP side.
  always_comb begin
    w_lane_byte = 8'h00;
    case (r_lane)
      2'd0:    w_lane_byte = ram_rd_i[7:0];
      2'd1:    w_lane_byte = ram_rd_i[15:8];
      2'd2:    w_lane_byte = ram_rd_i[23:16];
      2'd3:    w_lane_byte = ram_rd_i[31:24];
      default: w_lane_byte = 8'h00;
    endcase
  end

  // RAM data only arrives in RESP, so read data bypasses the holding register while ack is high.
  assign dp_rdata_o = (dp_ack_o && !r_we) ? w_lane_byte : r_dp_rdata;
  assign wb_dat_o   = (wb_ack_o && !r_we) ? ram_rd_i    : r_wb_dat;

  // Arbitration FSM with registered RAM command, acks, owner and starvation counter.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_we       <= 1'b0;
      r_lane     <= 2'd0;
      r_dp_rdata <= 8'h00;
      r_wb_dat   <= 32'h0000_0000;
      dp_ack_o   <= 1'b0;
      wb_ack_o   <= 1'b0;
      ram_a_o    <= '0;
      ram_wd_o   <= 32'h0000_0000;
      ram_wen_o  <= 4'b0000;
      owner_o    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          dp_ack_o <= 1'b0;
          wb_ack_o <= 1'b0;
          if (w_wb_req || w_dp_req) begin
            owner_o   <= w_win_wb;
            r_we      <= w_win_wb ? wb_we_i : dp_we_i;
            r_lane    <= dp_addr_i[1:0];
            ram_a_o   <= w_a;
            ram_wd_o  <= w_wd;
            ram_wen_o <= w_wen;
            // Only a priority grant over a waiting requester extends the run.
            if (w_both && (w_win_wb == exec_i)) begin
              r_cnt <= w_starved ? r_cnt : r_cnt + 4'd1;
            end else begin
              r_cnt <= 4'd0;
            end
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          ram_wen_o <= 4'b0000;
          if (owner_o) begin
            wb_ack_o <= w_wb_req;
          end else begin
            dp_ack_o <= w_dp_req;
          end
          r_state <= S_RESP;
        end
        S_RESP: begin
          if (dp_ack_o && !r_we) begin
            r_dp_rdata <= w_lane_byte;
          end
          if (wb_ack_o && !r_we) begin
            r_wb_dat <= ram_rd_i;
          end
          dp_ack_o <= 1'b0;
          wb_ack_o <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          dp_ack_o  <= 1'b0;
          wb_ack_o  <= 1'b0;
          ram_wen_o <= 4'b0000;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
